// File: rtl/ten_gig_eth_loop_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ten_gig_eth_loop_tx_arbiter_pkg
//  Shared definitions for the 10GbE loopback TX arbiter: default stream
//  widths, the arbiter state encoding and the next-grant decision used at
//  every frame boundary.
// ---------------------------------------------------------------------------
package ten_gig_eth_loop_tx_arbiter_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_APP   = 2'd1,
    GNT_LPB   = 2'd2,
    DRAIN_LPB = 2'd3
  } arb_state_e;

  // Arbitration at a frame boundary.
  //  loop_en    : loopback enable held in the register this cycle
  //  favour_lpb : round-robin pointer, 1 = loopback has the next turn
  // A pending loopback frame is drained when loopback is off, but never
  // ahead of a pending application frame.
  function automatic arb_state_e next_grant(input logic app_v,
                                            input logic lpb_v,
                                            input logic loop_en,
                                            input logic favour_lpb);
    arb_state_e nxt;
    nxt = IDLE;
    if (app_v && lpb_v) begin
      if (loop_en && favour_lpb) nxt = GNT_LPB;
      else                       nxt = GNT_APP;
    end else if (app_v) begin
      nxt = GNT_APP;
    end else if (lpb_v) begin
      nxt = loop_en ? GNT_LPB : DRAIN_LPB;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ten_gig_eth_loop_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ten_gig_eth_loop_tx_arbiter_if
//  AXI4-Stream bundle used for the application, loopback and MAC TX streams.
//   tdata  DATA_W     payload
//   tkeep  DATA_W/8   byte enables (passed through unchecked)
//   tlast  1          last beat of frame
//   tvalid 1          source has a beat
//   tready 1          sink accepts the beat
//  master: drives tdata/tkeep/tlast/tvalid, receives tready
//  slave : receives tdata/tkeep/tlast/tvalid, drives tready
// ---------------------------------------------------------------------------
interface ten_gig_eth_loop_tx_arbiter_if
  import ten_gig_eth_loop_tx_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int KEEP_W = DATA_W / BYTE_W;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/ten_gig_eth_loop_tx_arbiter_sat_cnt.sv
// ---------------------------------------------------------------------------
// ten_gig_eth_sat_cnt
//  CNT_W-bit event counter that sticks at its maximum value.
//   clk   in  1      rising-edge clock
//   rst_n in  1      asynchronous active-low reset (count -> 0)
//   clr   in  1      synchronous clear, has priority over inc
//   inc   in  1      count one event
//   cnt   out CNT_W  current count
// ---------------------------------------------------------------------------
module ten_gig_eth_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ten_gig_eth_loop_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ten_gig_eth_loop_tx_arbiter
//  Frame-level 2:1 AXI4-Stream arbiter in front of the 10GbE MAC TX path.
//  Source app = application TX, source lpb = loopback (RX through the MAC
//  address swapper). The loopback enable is sampled only at frame
//  boundaries and drives poSwapEn, so routing and swapping never change in
//  the middle of a frame. With loopback off, loopback frames are accepted
//  and discarded so the RX path never backs up.
//  Ports:
//   piEthCoreClk  in  1      core clock, rising edge
//   piReset_n     in  1      asynchronous active-low reset
//   piLoopEn      in  1      requested loopback enable (quasi-static)
//   poSwapEn      out 1      frame-aligned enable to the address swapper
//   piClrCnt      in  1      synchronous clear of all frame counters
//   app           slave      application TX stream
//   lpb           slave      loopback stream
//   mac           master     stream to MAC TX
//   poAppFrmCnt   out CNT_W  frames forwarded from app (saturating)
//   poLpbFrmCnt   out CNT_W  frames forwarded from lpb (saturating)
//   poDrpFrmCnt   out CNT_W  lpb frames drained while disabled (saturating)
// ---------------------------------------------------------------------------
module ten_gig_eth_loop_tx_arbiter
  import ten_gig_eth_loop_tx_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                          piEthCoreClk,
  input  logic                          piReset_n,
  input  logic                          piLoopEn,
  output logic                          poSwapEn,
  input  logic                          piClrCnt,
  ten_gig_eth_loop_tx_arbiter_if.slave  app,
  ten_gig_eth_loop_tx_arbiter_if.slave  lpb,
  ten_gig_eth_loop_tx_arbiter_if.master mac,
  output logic [CNT_W-1:0]              poAppFrmCnt,
  output logic [CNT_W-1:0]              poLpbFrmCnt,
  output logic [CNT_W-1:0]              poDrpFrmCnt
);

  localparam int KEEP_W = DATA_W / BYTE_W;

  arb_state_e state_q, state_nxt;
  logic       loop_en_q, loop_en_nxt;
  logic       rr_ptr_q, rr_ptr_nxt;   // 1 = loopback has the next turn
  logic       sof_q, sof_nxt;         // no beat of the granted frame moved yet

  logic              sel_lpb;
  logic              mac_valid;
  logic              app_ready;
  logic              lpb_ready;
  logic              app_inc;
  logic              lpb_inc;
  logic              drp_inc;
  logic [DATA_W-1:0] mux_data;
  logic [KEEP_W-1:0] mux_keep;
  logic              mux_last;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge piEthCoreClk or negedge piReset_n) begin
    if (!piReset_n) begin
      state_q   <= IDLE;
      loop_en_q <= 1'b0;
      rr_ptr_q  <= 1'b0;
      sof_q     <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      loop_en_q <= loop_en_nxt;
      rr_ptr_q  <= rr_ptr_nxt;
      sof_q     <= sof_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and handshake control
  // On a tlast beat the grant for the following frame is decided in the same
  // edge, so back-to-back frames flow with no idle cycle. The grant decision
  // sees the granted source's own tvalid (its tlast beat); if that source
  // then has no new frame, the sof_q escape returns to IDLE before any beat
  // of the new frame moved, so a silent source cannot lock out the other.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state_q;
    loop_en_nxt = loop_en_q;
    rr_ptr_nxt  = rr_ptr_q;
    sof_nxt     = sof_q;
    sel_lpb     = 1'b0;
    mac_valid   = 1'b0;
    app_ready   = 1'b0;
    lpb_ready   = 1'b0;
    app_inc     = 1'b0;
    lpb_inc     = 1'b0;
    drp_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        loop_en_nxt = piLoopEn;
        sof_nxt     = 1'b1;
        state_nxt   = next_grant(app.tvalid, lpb.tvalid, loop_en_q, rr_ptr_q);
      end

      GNT_APP: begin
        mac_valid = app.tvalid;
        app_ready = mac.tready;
        if (app.tvalid && mac.tready) begin
          sof_nxt = app.tlast;
          if (app.tlast) begin
            app_inc     = 1'b1;
            rr_ptr_nxt  = 1'b1;
            loop_en_nxt = piLoopEn;
            state_nxt   = next_grant(app.tvalid, lpb.tvalid, loop_en_q, 1'b1);
          end
        end else if (sof_q && !app.tvalid) begin
          state_nxt = IDLE;
        end
      end

      GNT_LPB: begin
        sel_lpb   = 1'b1;
        mac_valid = lpb.tvalid;
        lpb_ready = mac.tready;
        if (lpb.tvalid && mac.tready) begin
          sof_nxt = lpb.tlast;
          if (lpb.tlast) begin
            lpb_inc     = 1'b1;
            rr_ptr_nxt  = 1'b0;
            loop_en_nxt = piLoopEn;
            state_nxt   = next_grant(app.tvalid, lpb.tvalid, loop_en_q, 1'b0);
          end
        end else if (sof_q && !lpb.tvalid) begin
          state_nxt = IDLE;
        end
      end

      DRAIN_LPB: begin
        // Loopback data is swallowed; the MAC sees nothing.
        lpb_ready = 1'b1;
        if (lpb.tvalid) begin
          sof_nxt = lpb.tlast;
          if (lpb.tlast) begin
            drp_inc     = 1'b1;
            loop_en_nxt = piLoopEn;
            state_nxt   = next_grant(app.tvalid, lpb.tvalid, loop_en_q, rr_ptr_q);
          end
        end else if (sof_q) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Zero-latency output mux
  // -------------------------------------------------------------------------
  always_comb begin
    mux_data = app.tdata;
    mux_keep = app.tkeep;
    mux_last = app.tlast;
    if (sel_lpb) begin
      mux_data = lpb.tdata;
      mux_keep = lpb.tkeep;
      mux_last = lpb.tlast;
    end
  end

  assign mac.tdata  = mux_data;
  assign mac.tkeep  = mux_keep;
  assign mac.tlast  = mux_last;
  assign mac.tvalid = mac_valid;
  assign app.tready = app_ready;
  assign lpb.tready = lpb_ready;
  assign poSwapEn   = loop_en_q;

  // -------------------------------------------------------------------------
  // Frame counters
  // -------------------------------------------------------------------------
  ten_gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_app_cnt (
    .clk   (piEthCoreClk),
    .rst_n (piReset_n),
    .clr   (piClrCnt),
    .inc   (app_inc),
    .cnt   (poAppFrmCnt)
  );

  ten_gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_lpb_cnt (
    .clk   (piEthCoreClk),
    .rst_n (piReset_n),
    .clr   (piClrCnt),
    .inc   (lpb_inc),
    .cnt   (poLpbFrmCnt)
  );

  ten_gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_drp_cnt (
    .clk   (piEthCoreClk),
    .rst_n (piReset_n),
    .clr   (piClrCnt),
    .inc   (drp_inc),
    .cnt   (poDrpFrmCnt)
  );

endmodule

// File: tb/tb_ten_gig_eth_loop_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ten_gig_eth_loop_tx_arbiter
//  Self-checking bench for the loopback TX arbiter. Expected MAC beats are
//  queued when a scenario sets up its stimulus; a monitor pops and compares
//  every accepted MAC beat. Counters use CNT_W=4 so saturation is reachable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ten_gig_eth_loop_tx_arbiter;

  localparam int DW = 64;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] k;
    logic            l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop_en = 1'b0;
  logic clr_cnt = 1'b0;
  logic swap_en;
  logic [CW-1:0] app_cnt, lpb_cnt, drp_cnt;

  ten_gig_eth_loop_tx_arbiter_if #(.DATA_W(DW)) app_if ();
  ten_gig_eth_loop_tx_arbiter_if #(.DATA_W(DW)) lpb_if ();
  ten_gig_eth_loop_tx_arbiter_if #(.DATA_W(DW)) mac_if ();

  ten_gig_eth_loop_tx_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .piEthCoreClk (clk),
    .piReset_n    (rst_n),
    .piLoopEn     (loop_en),
    .poSwapEn     (swap_en),
    .piClrCnt     (clr_cnt),
    .app          (app_if),
    .lpb          (lpb_if),
    .mac          (mac_if),
    .poAppFrmCnt  (app_cnt),
    .poLpbFrmCnt  (lpb_cnt),
    .poDrpFrmCnt  (drp_cnt)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];
  int unsigned cyc = 0;
  int unsigned last_beat_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t mk_beat(input bit src, input logic [7:0] id,
                                    input int unsigned b, input int unsigned len);
    beat_t bt;
    bt.d = {(src ? 8'hB1 : 8'hA0), id, 8'(b), 40'h13579BDF02};
    bt.l = (b == len - 1);
    bt.k = bt.l ? 8'h0F : 8'hFF;
    return bt;
  endfunction

  function automatic void push_frame(input bit src, input logic [7:0] id,
                                     input int unsigned first, input int unsigned count,
                                     input int unsigned len);
    for (int unsigned b = first; b < first + count; b++) sb.push_back(mk_beat(src, id, b, len));
  endfunction

  // Scoreboard monitor: sampled on the falling edge, between drive and accept.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mac_if.tvalid === 1'b1 && mac_if.tready === 1'b1) begin
      beat_t got, exp;
      last_beat_cyc = cyc;
      got = {mac_if.tdata, mac_if.tkeep, mac_if.tlast};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL mac_unexpected_beat got=%h required=no beat", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL mac_beat got=%h required=%h", got, exp);
        end
      end
    end
  end

  // Sends beats [first, first+count) of a len-beat frame on one source.
  task automatic drive(input bit src, input logic [7:0] id, input int unsigned first,
                       input int unsigned count, input int unsigned len);
    beat_t       bt;
    bit          acc;
    int unsigned waitc;
    for (int unsigned b = first; b < first + count; b++) begin
      bt = mk_beat(src, id, b, len);
      if (!src) begin
        app_if.tdata = bt.d; app_if.tkeep = bt.k; app_if.tlast = bt.l; app_if.tvalid = 1'b1;
      end else begin
        lpb_if.tdata = bt.d; lpb_if.tkeep = bt.k; lpb_if.tlast = bt.l; lpb_if.tvalid = 1'b1;
      end
      acc   = 1'b0;
      waitc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = src ? lpb_if.tready : app_if.tready;
        @(posedge clk);
        #1;
        waitc++;
        if (!acc && waitc > 300) begin
          total++;
          bad++;
          $display("FAIL handshake_timeout src=%0d id=%0d beat=%0d waited=%0d required<=300",
                   src, id, b, waitc);
          if (!src) app_if.tvalid = 1'b0; else lpb_if.tvalid = 1'b0;
          return;
        end
      end
    end
    if (!src) app_if.tvalid = 1'b0; else lpb_if.tvalid = 1'b0;
  endtask

  task automatic do_reset(input logic le);
    rst_n = 1'b0;
    loop_en = le;
    clr_cnt = 1'b0;
    app_if.tvalid = 1'b0;
    lpb_if.tvalid = 1'b0;
    mac_if.tready = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mac_if.tready = 1'b1;
    app_if.tvalid = 1'b1; app_if.tlast = 1'b0; app_if.tdata = '0; app_if.tkeep = '1;
    lpb_if.tvalid = 1'b1; lpb_if.tlast = 1'b0; lpb_if.tdata = '0; lpb_if.tkeep = '1;
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (mac_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_mac_tvalid got=%b required=0", mac_if.tvalid); end
    total++; if (app_if.tready !== 1'b0) begin bad++; $display("FAIL rst_app_tready got=%b required=0", app_if.tready); end
    total++; if (lpb_if.tready !== 1'b0) begin bad++; $display("FAIL rst_lpb_tready got=%b required=0", lpb_if.tready); end
    total++; if (swap_en !== 1'b0) begin bad++; $display("FAIL rst_swap_en got=%b required=0", swap_en); end
    total++; if ({app_cnt, lpb_cnt, drp_cnt} !== '0) begin bad++; $display("FAIL rst_counters got=%h/%h/%h required=0/0/0", app_cnt, lpb_cnt, drp_cnt); end
    app_if.tvalid = 1'b0;
    lpb_if.tvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    int unsigned first_cyc = 0;
    bit          seen = 1'b0;
    do_reset(1'b1);
    push_frame(0, 8'd1, 0, 8, 8);
    push_frame(1, 8'd2, 0, 8, 8);
    push_frame(0, 8'd3, 0, 8, 8);
    push_frame(1, 8'd4, 0, 8, 8);
    fork
      begin drive(0, 8'd1, 0, 8, 8); drive(0, 8'd3, 0, 8, 8); end
      begin drive(1, 8'd2, 0, 8, 8); drive(1, 8'd4, 0, 8, 8); end
      begin
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (mac_if.tvalid && mac_if.tready) begin seen = 1'b1; first_cyc = cyc; end
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    total++; if (!seen || (last_beat_cyc - first_cyc) != 31) begin bad++; $display("FAIL rr_no_bubble got_span=%0d required=31", last_beat_cyc - first_cyc); end
    total++; if (app_cnt !== 4'd2) begin bad++; $display("FAIL rr_app_cnt got=%0d required=2", app_cnt); end
    total++; if (lpb_cnt !== 4'd2) begin bad++; $display("FAIL rr_lpb_cnt got=%0d required=2", lpb_cnt); end
    total++; if (swap_en !== 1'b1) begin bad++; $display("FAIL rr_swap_en got=%b required=1", swap_en); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rr_sb_left got=%0d required=0", sb.size()); end
  endtask

  task automatic test_drain();
    int  mac_seen = 0;
    int  ready_low = 0;
    bit  done = 1'b0;
    do_reset(1'b0);
    fork
      begin
        drive(1, 8'd10, 0, 4, 4); drive(1, 8'd11, 0, 4, 4); drive(1, 8'd12, 0, 4, 4);
        done = 1'b1;
      end
      begin
        for (int i = 0; i < 200 && !done; i++) begin
          @(negedge clk);
          if (mac_if.tvalid !== 1'b0) mac_seen++;
          if (lpb_if.tvalid && lpb_if.tready !== 1'b1) ready_low++;
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    total++; if (mac_seen != 0) begin bad++; $display("FAIL drain_mac_tvalid got=%0d cycles required=0", mac_seen); end
    total++; if (ready_low != 1) begin bad++; $display("FAIL drain_lpb_tready_low got=%0d required=1 (arbitration cycle)", ready_low); end
    total++; if (drp_cnt !== 4'd3) begin bad++; $display("FAIL drain_drp_cnt got=%0d required=3", drp_cnt); end
    total++; if (lpb_cnt !== 4'd0) begin bad++; $display("FAIL drain_lpb_cnt got=%0d required=0", lpb_cnt); end
    total++; if (swap_en !== 1'b0) begin bad++; $display("FAIL drain_swap_en got=%b required=0", swap_en); end
  endtask

  task automatic test_loop_toggle();
    do_reset(1'b0);
    push_frame(0, 8'd5, 0, 10, 10);
    drive(0, 8'd5, 0, 4, 10);
    loop_en = 1'b1;
    drive(0, 8'd5, 4, 5, 10);
    total++; if (swap_en !== 1'b0) begin bad++; $display("FAIL toggle_swap_midframe got=%b required=0", swap_en); end
    drive(0, 8'd5, 9, 1, 10);
    total++; if (swap_en !== 1'b1) begin bad++; $display("FAIL toggle_swap_after_tlast got=%b required=1", swap_en); end
    push_frame(1, 8'd6, 0, 4, 4);
    drive(1, 8'd6, 0, 4, 4);
    repeat (2) @(posedge clk);
    #1;
    total++; if (lpb_cnt !== 4'd1) begin bad++; $display("FAIL toggle_lpb_cnt got=%0d required=1", lpb_cnt); end
    total++; if (drp_cnt !== 4'd0) begin bad++; $display("FAIL toggle_drp_cnt got=%0d required=0", drp_cnt); end
    total++; if (app_cnt !== 4'd1) begin bad++; $display("FAIL toggle_app_cnt got=%0d required=1", app_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL toggle_sb_left got=%0d required=0", sb.size()); end
  endtask

  task automatic test_stall();
    int            viol = 0;
    logic [DW-1:0] held = '0;
    do_reset(1'b1);
    push_frame(1, 8'd7, 0, 8, 8);
    push_frame(0, 8'd8, 0, 2, 2);
    fork
      drive(1, 8'd7, 0, 8, 8);
      begin repeat (2) @(posedge clk); #1; drive(0, 8'd8, 0, 2, 2); end
      begin
        repeat (4) @(posedge clk);
        #1 mac_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 0) held = mac_if.tdata;
          if (mac_if.tvalid !== 1'b1 || mac_if.tdata !== held || app_if.tready !== 1'b0 ||
              lpb_if.tready !== 1'b0 || held[63:56] !== 8'hB1) viol++;
          @(posedge clk);
        end
        #1 mac_if.tready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    total++; if (viol != 0) begin bad++; $display("FAIL stall_hold got=%0d bad cycles required=0", viol); end
    total++; if (lpb_cnt !== 4'd1 || app_cnt !== 4'd1) begin bad++; $display("FAIL stall_counts got=lpb %0d app %0d required=1 1", lpb_cnt, app_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_sb_left got=%0d required=0", sb.size()); end
  endtask

  task automatic test_saturate_clear();
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      push_frame(0, 8'(i), 0, 1, 1);
      drive(0, 8'(i), 0, 1, 1);
    end
    total++; if (app_cnt !== 4'hF) begin bad++; $display("FAIL sat_reach got=%0d required=15", app_cnt); end
    push_frame(0, 8'd40, 0, 1, 1);
    drive(0, 8'd40, 0, 1, 1);
    total++; if (app_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0d required=15", app_cnt); end
    push_frame(0, 8'd41, 0, 2, 2);
    drive(0, 8'd41, 0, 1, 2);
    clr_cnt = 1'b1;
    drive(0, 8'd41, 1, 1, 2);
    clr_cnt = 1'b0;
    total++; if (app_cnt !== 4'd0) begin bad++; $display("FAIL clr_on_tlast got=%0d required=0", app_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sat_sb_left got=%0d required=0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    beat_t bt;
    do_reset(1'b1);
    push_frame(0, 8'd19, 0, 2, 2);
    drive(0, 8'd19, 0, 2, 2);
    total++; if (app_cnt !== 4'd1) begin bad++; $display("FAIL mrst_pre_cnt got=%0d required=1", app_cnt); end
    push_frame(0, 8'd20, 0, 3, 8);
    drive(0, 8'd20, 0, 3, 8);
    bt = mk_beat(0, 8'd20, 3, 8);
    app_if.tdata = bt.d; app_if.tkeep = bt.k; app_if.tlast = bt.l; app_if.tvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (mac_if.tvalid !== 1'b0) begin bad++; $display("FAIL mrst_mac_tvalid got=%b required=0", mac_if.tvalid); end
    total++; if (app_if.tready !== 1'b0 || lpb_if.tready !== 1'b0) begin bad++; $display("FAIL mrst_treadies got=%b%b required=00", app_if.tready, lpb_if.tready); end
    app_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({app_cnt, lpb_cnt, drp_cnt} !== '0) begin bad++; $display("FAIL mrst_counters got=%h/%h/%h required=0/0/0", app_cnt, lpb_cnt, drp_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL mrst_partial_left got=%0d required=0", sb.size()); end
    push_frame(0, 8'd21, 0, 4, 4);
    drive(0, 8'd21, 0, 4, 4);
    @(posedge clk);
    #1;
    total++; if (app_cnt !== 4'd1) begin bad++; $display("FAIL mrst_post_cnt got=%0d required=1", app_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL mrst_sb_left got=%0d required=0", sb.size()); end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_drain();
    test_loop_toggle();
    test_stall();
    test_saturate_clear();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
